model_cycle_sched: RTL

Cycle scheduler that sequences the DPI-backed cache C-model wrapper. It holds the model in its init phase for a fixed number of clocks, then issues numbered model cycles one at a time over a cycle_valid/done handshake. It supports run, pause, single-step, abort and a configurable cycle limit, with a watchdog on the done handshake. It sits between the testbench/top-level control and the model wrapper, driving the wrapper's reset, cycle_valid and cycle_num inputs.

---
 rtl/model_cycle_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/model_cycle_sched.sv
// Cycle scheduler for the cache C-model wrapper: holds the model in init, then
// issues numbered model cycles over a cycle_valid/done handshake with run/pause/step/abort.
module model_cycle_sched #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_max_cycles,
  output logic             model_rst,
  output logic             cycle_valid,
  output logic [CNT_W-1:0] cycle_num,
  input  logic             done,
  output logic             busy,
  output logic             paused,
  output logic             finished,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycles_done
);

  localparam int unsigned IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(INIT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT, S_READY, S_ISSUE, S_WAIT, S_PAUSED, S_FINISH, S_ERROR
  } state_t;

  state_t            state;
  state_t            accept_next;
  logic [IC_W-1:0]   init_cnt;
  logic [WD_W-1:0]   wdog;
  logic [CNT_W-1:0]  max_cycles;
  logic [CNT_W-1:0]  done_inc;

  // Where an accepted cycle goes next; the limit test uses the wrapped CNT_W-bit count.
  always_comb begin
    done_inc    = cycles_done + CNT_W'(1);
    accept_next = S_ISSUE;
    if (abort)                        accept_next = S_FINISH;
    else if (done_inc == max_cycles)  accept_next = S_FINISH;
    else if (pause)                   accept_next = S_PAUSED;
  end

  always_comb begin
    busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_PAUSED);
    paused   = (state == S_PAUSED);
    finished = (state == S_FINISH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      wdog        <= '0;
      max_cycles  <= '0;
      model_rst   <= 1'b1;
      cycle_valid <= 1'b0;
      cycle_num   <= '0;
      cycles_done <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + IC_W'(1);
          if (init_cnt == IC_LAST) begin
            model_rst <= 1'b0;
            state     <= S_READY;
          end
        end
        S_READY: begin
          if (start) begin
            max_cycles  <= cfg_max_cycles;
            cycle_num   <= '0;
            cycles_done <= '0;
            if (cfg_max_cycles == '0) begin
              state <= S_FINISH;
            end else begin
              state       <= S_ISSUE;
              cycle_valid <= 1'b1;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          // Acceptance outranks abort so a cycle completing this clock is still counted.
          if (done) begin
            cycles_done <= done_inc;
            cycle_num   <= cycle_num + CNT_W'(1);
            state       <= accept_next;
            cycle_valid <= (accept_next == S_ISSUE);
          end else if (abort) begin
            state       <= S_FINISH;
            cycle_valid <= 1'b0;
          end else if (state == S_ISSUE) begin
            state       <= S_WAIT;
            cycle_valid <= 1'b0;
            wdog        <= '0;
          end else if (wdog == WD_LAST) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_PAUSED: begin
          if (abort) begin
            state <= S_FINISH;
          end else if (!pause || step) begin
            state       <= S_ISSUE;
            cycle_valid <= 1'b1;
          end
        end
        S_FINISH: begin
          if (start) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            model_rst <= 1'b1;
          end
        end
        S_ERROR: begin
          cycle_valid <= 1'b0;
        end
        default: begin
          state <= S_ERROR;
        end
      endcase
    end
  end

endmodule
